dispense_sequencer: RTL and testbench

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

---
 rtl/dispense_pkg.sv | 38 +++
 rtl/dispense_sequencer_seq_timer.sv | 39 +++
 rtl/dispense_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_dispense_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dispense_pkg.sv
// -----------------------------------------------------------------------------
// dispense_pkg
// Shared definitions for the dispense sequencer: command codes, FSM state
// encoding and small constant helpers used to size and load the phase timer.
// No ports (package).
// -----------------------------------------------------------------------------
package dispense_pkg;

   // Command byte codes received over the UART
   localparam logic [7:0] CMD_STOP  = 8'h00;
   localparam logic [7:0] CMD_POUR  = 8'h01;
   localparam logic [7:0] CMD_MOTOR = 8'h02;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRIME     = 2'd1,
      ST_POUR      = 2'd2,
      ST_MOTOR_RUN = 2'd3
   } state_t;

   // A zero-length phase is stretched to one cycle so every phase is observable
   function automatic int unsigned eff_cycles(input int unsigned c);
      return (c == 32'd0) ? 32'd1 : c;
   endfunction

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      else m = m;
      if (c > m) m = c;
      else m = m;
      return m;
   endfunction

endpackage

// File: rtl/dispense_sequencer_seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Down-counter that times one phase of the dispense sequence. A load writes
// the phase length minus one; the counter then decrements to zero and holds.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset (counter -> 0)
//   load   in   load value into the counter this cycle
//   value  in   W-bit load value
//   zero   out  counter currently equals zero
// -----------------------------------------------------------------------------
module seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] count_r;

   // Phase counter: load has priority, otherwise count down and stick at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= value;
      end else if (count_r != {W{1'b0}}) begin
         count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/dispense_sequencer.sv
// -----------------------------------------------------------------------------
// dispense_sequencer
// Command-driven sequencer for a pump/valve pour and a timed motor run.
// Commands arrive as bytes with a one-cycle strobe: 0x00 STOP, 0x01 POUR
// (prime with pump only, then pump + valve), 0x02 MOTOR. All outputs are
// registered; done and err are single-cycle pulses.
// Optional build macro DISPENSE_INTERLOCK_EN adds input interlock_ok: starts
// are refused while it is low, and a running sequence is aborted (with err)
// if it drops.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   cmd_data     in   8-bit command byte
//   cmd_valid    in   single-cycle qualifier for cmd_data
//   interlock_ok in   (DISPENSE_INTERLOCK_EN only) external permissive
//   motor        out  motor drive
//   pump         out  pump drive
//   valve        out  valve drive
//   busy         out  sequence in progress
//   done         out  pulse on normal sequence completion
//   err          out  pulse on rejected command / interlock abort
//   led          out  last accepted command byte
// -----------------------------------------------------------------------------
module dispense_sequencer
   import dispense_pkg::*;
#(
   parameter int unsigned PRIME_CYCLES = 100_000_000,
   parameter int unsigned POUR_CYCLES  = 300_000_000,
   parameter int unsigned MOTOR_CYCLES = 200_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
`ifdef DISPENSE_INTERLOCK_EN
   input  logic       interlock_ok,
`endif
   output logic       motor,
   output logic       pump,
   output logic       valve,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] led
);

   localparam int unsigned PRIME_EFF = eff_cycles(PRIME_CYCLES);
   localparam int unsigned POUR_EFF  = eff_cycles(POUR_CYCLES);
   localparam int unsigned MOTOR_EFF = eff_cycles(MOTOR_CYCLES);
   localparam int CNT_W = $clog2(max3(PRIME_EFF, POUR_EFF, MOTOR_EFF)) + 1;

   localparam logic [CNT_W-1:0] PRIME_LOAD = CNT_W'(PRIME_EFF - 32'd1);
   localparam logic [CNT_W-1:0] POUR_LOAD  = CNT_W'(POUR_EFF - 32'd1);
   localparam logic [CNT_W-1:0] MOTOR_LOAD = CNT_W'(MOTOR_EFF - 32'd1);

   state_t           state_r;
   logic             motor_r;
   logic             pump_r;
   logic             valve_r;
   logic             busy_r;
   logic             done_r;
   logic             err_r;
   logic [7:0]       led_r;

   logic             is_stop_s;
   logic             is_start_s;
   logic             is_bad_s;
   logic             can_start_s;
   logic             abort_s;
   logic             tmr_load_s;
   logic [CNT_W-1:0] tmr_value_s;
   logic             tmr_zero_s;

   // Command decode, start permission and interlock abort condition
   always_comb begin
      is_stop_s  = cmd_valid && (cmd_data == CMD_STOP);
      is_start_s = cmd_valid && ((cmd_data == CMD_POUR) || (cmd_data == CMD_MOTOR));
      is_bad_s   = cmd_valid && !is_stop_s && !is_start_s;
`ifdef DISPENSE_INTERLOCK_EN
      can_start_s = (state_r == ST_IDLE) && interlock_ok;
      // Starts require interlock_ok, so low while busy means it fell mid-run
      abort_s     = (state_r != ST_IDLE) && !interlock_ok;
`else
      can_start_s = (state_r == ST_IDLE);
      abort_s     = 1'b0;
`endif
   end

   // Timer load: phase entry loads length-1, stop/abort clears to zero
   always_comb begin
      tmr_load_s  = 1'b0;
      tmr_value_s = {CNT_W{1'b0}};
      if (is_stop_s || abort_s) begin
         tmr_load_s  = 1'b1;
         tmr_value_s = {CNT_W{1'b0}};
      end else if (is_start_s && can_start_s) begin
         tmr_load_s  = 1'b1;
         tmr_value_s = (cmd_data == CMD_POUR) ? PRIME_LOAD : MOTOR_LOAD;
      end else if ((state_r == ST_PRIME) && tmr_zero_s) begin
         tmr_load_s  = 1'b1;
         tmr_value_s = POUR_LOAD;
      end else begin
         tmr_load_s  = 1'b0;
         tmr_value_s = {CNT_W{1'b0}};
      end
   end

   seq_timer #(
      .W(CNT_W)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load_s),
      .value (tmr_value_s),
      .zero  (tmr_zero_s)
   );

   // Sequencer FSM with registered drives and status pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         motor_r <= 1'b0;
         pump_r  <= 1'b0;
         valve_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         led_r   <= 8'h00;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         if (is_stop_s) begin
            // STOP wins over everything, including a phase ending this cycle
            state_r <= ST_IDLE;
            motor_r <= 1'b0;
            pump_r  <= 1'b0;
            valve_r <= 1'b0;
            busy_r  <= 1'b0;
            led_r   <= cmd_data;
         end else if (abort_s) begin
            state_r <= ST_IDLE;
            motor_r <= 1'b0;
            pump_r  <= 1'b0;
            valve_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b1;
         end else begin
            // Invalid codes and starts that cannot be taken are refused
            err_r <= is_bad_s || (is_start_s && !can_start_s);
            case (state_r)
               ST_IDLE: begin
                  if (is_start_s && can_start_s) begin
                     led_r  <= cmd_data;
                     busy_r <= 1'b1;
                     if (cmd_data == CMD_POUR) begin
                        state_r <= ST_PRIME;
                        pump_r  <= 1'b1;
                     end else begin
                        state_r <= ST_MOTOR_RUN;
                        motor_r <= 1'b1;
                     end
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_PRIME: begin
                  if (tmr_zero_s) begin
                     state_r <= ST_POUR;
                     valve_r <= 1'b1;
                  end else begin
                     state_r <= ST_PRIME;
                  end
               end
               ST_POUR: begin
                  if (tmr_zero_s) begin
                     state_r <= ST_IDLE;
                     pump_r  <= 1'b0;
                     valve_r <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_POUR;
                  end
               end
               ST_MOTOR_RUN: begin
                  if (tmr_zero_s) begin
                     state_r <= ST_IDLE;
                     motor_r <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_MOTOR_RUN;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  motor_r <= 1'b0;
                  pump_r  <= 1'b0;
                  valve_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign motor = motor_r;
   assign pump  = pump_r;
   assign valve = valve_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign err   = err_r;
   assign led   = led_r;

endmodule

// File: tb/tb_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dispense_sequencer
// Directed bench for dispense_sequencer with PRIME=4, POUR=6, MOTOR=5.
// Inputs change and outputs are sampled on the falling clock edge; cycle k
// below counts cycles after the one in which a command was presented.
// Build with DISPENSE_INTERLOCK_EN to add the interlock scenarios.
// -----------------------------------------------------------------------------
module tb_dispense_sequencer;

   logic       clk;
   logic       reset;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       interlock_ok;
   logic       motor;
   logic       pump;
   logic       valve;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] led;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   dispense_sequencer #(
      .PRIME_CYCLES (4),
      .POUR_CYCLES  (6),
      .MOTOR_CYCLES (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_data     (cmd_data),
      .cmd_valid    (cmd_valid),
`ifdef DISPENSE_INTERLOCK_EN
      .interlock_ok (interlock_ok),
`endif
      .motor        (motor),
      .pump         (pump),
      .valve        (valve),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .led          (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present inputs for the current cycle, then move to the next falling edge
   task automatic step(input logic v, input logic [7:0] d);
      cmd_valid = v;
      cmd_data  = d;
      @(negedge clk);
   endtask

   task automatic chk_idle(input string tag, input logic [7:0] exp_led);
      chk({tag, ".motor"}, {31'd0, motor}, 32'd0);
      chk({tag, ".pump"},  {31'd0, pump},  32'd0);
      chk({tag, ".valve"}, {31'd0, valve}, 32'd0);
      chk({tag, ".busy"},  {31'd0, busy},  32'd0);
      chk({tag, ".led"},   {24'd0, led},   {24'd0, exp_led});
   endtask

   // Full pour; optionally inject a command in cycle inj_k (0 = none)
   task automatic pour_run(input string tag, input int inj_k, input logic [7:0] inj_cmd);
      step(1'b1, 8'h01);
      for (int k = 1; k <= 11; k++) begin
         chk($sformatf("%s.pump@%0d", tag, k),  {31'd0, pump},  {31'd0, (k <= 10)});
         chk($sformatf("%s.valve@%0d", tag, k), {31'd0, valve}, {31'd0, (k >= 5 && k <= 10)});
         chk($sformatf("%s.motor@%0d", tag, k), {31'd0, motor}, 32'd0);
         chk($sformatf("%s.busy@%0d", tag, k),  {31'd0, busy},  {31'd0, (k <= 10)});
         chk($sformatf("%s.done@%0d", tag, k),  {31'd0, done},  {31'd0, (k == 11)});
         chk($sformatf("%s.err@%0d", tag, k),   {31'd0, err},   {31'd0, (inj_k != 0 && k == inj_k + 1)});
         step((k == inj_k), (k == inj_k) ? inj_cmd : 8'h00);
      end
      chk_idle({tag, ".after"}, 8'h01);
      chk({tag, ".done_after"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      cmd_valid    = 1'b0;
      cmd_data     = 8'h00;
      interlock_ok = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      chk_idle("rst", 8'h00);
      chk("rst.done", {31'd0, done}, 32'd0);
      chk("rst.err",  {31'd0, err},  32'd0);
      reset = 1'b0;
      step(1'b0, 8'h00);
      chk_idle("post_rst", 8'h00);

      // Normal pour: pump k=1..10, valve k=5..10, done k=11
      pour_run("pour", 0, 8'h00);

      // Motor run: motor k=1..5, done k=6
      step(1'b1, 8'h02);
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("mot.motor@%0d", k), {31'd0, motor}, {31'd0, (k <= 5)});
         chk($sformatf("mot.pump@%0d", k),  {31'd0, pump},  32'd0);
         chk($sformatf("mot.valve@%0d", k), {31'd0, valve}, 32'd0);
         chk($sformatf("mot.done@%0d", k),  {31'd0, done},  {31'd0, (k == 6)});
         step(1'b0, 8'h00);
      end
      chk("mot.led", {24'd0, led}, 32'h02);

      // MOTOR during POUR: err pulse, pour timing unchanged
      pour_run("pour_m", 7, 8'h02);

      // POUR on the final POUR cycle counts as busy: rejected, no restart
      pour_run("pour_end", 10, 8'h01);

      // STOP during PRIME: everything off next cycle, no done afterwards
      step(1'b1, 8'h01);
      step(1'b0, 8'h00);
      chk("stop.pump_pre", {31'd0, pump}, 32'd1);
      step(1'b1, 8'h00);
      chk_idle("stop", 8'h00);
      chk("stop.done", {31'd0, done}, 32'd0);
      chk("stop.err",  {31'd0, err},  32'd0);
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 8'h00);
         chk($sformatf("stop.nodone@%0d", k), {31'd0, done}, 32'd0);
         chk($sformatf("stop.nopump@%0d", k), {31'd0, pump}, 32'd0);
      end

      // Invalid code in IDLE: err, led unchanged, still idle
      step(1'b1, 8'h7F);
      chk("bad.err", {31'd0, err}, 32'd1);
      chk_idle("bad", 8'h00);
      step(1'b0, 8'h00);
      chk("bad.err_clr", {31'd0, err}, 32'd0);

      // Reset mid-MOTOR_RUN: motor drops without waiting for a clock
      step(1'b1, 8'h02);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      chk("rmid.motor_pre", {31'd0, motor}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk_idle("rmid", 8'h00);
      @(negedge clk);
      reset = 1'b0;
      pour_run("pour_rst", 0, 8'h00);

`ifdef DISPENSE_INTERLOCK_EN
      // Interlock drops in POUR (k=6): abort with err next cycle
      step(1'b1, 8'h01);
      for (int k = 1; k <= 5; k++) step(1'b0, 8'h00);
      chk("il.valve_pre", {31'd0, valve}, 32'd1);
      interlock_ok = 1'b0;
      step(1'b0, 8'h00);
      chk_idle("il_abort", 8'h01);
      chk("il_abort.err",  {31'd0, err},  32'd1);
      chk("il_abort.done", {31'd0, done}, 32'd0);
      // POUR while interlock is low is refused
      step(1'b1, 8'h01);
      chk("il_rej.err", {31'd0, err}, 32'd1);
      chk_idle("il_rej", 8'h01);
      interlock_ok = 1'b1;
      step(1'b0, 8'h00);
      chk("il_rej.err_clr", {31'd0, err}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
